batch_scheduler: RTL

//  Sequences several pixel-processor cores that feed one pixel FIFO. Hands out consecutive

---
 rtl/batch_scheduler_if.sv | 43 ++++
 rtl/batch_scheduler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/batch_scheduler_if.sv
// Handshake bundle between batch_scheduler, its pixel cores and the pixel FIFO.
//   new_frame    frame timing -> scheduler, 1-cycle restart pulse
//   fifo_ready   FIFO -> scheduler, room for at least two batches
//   core_done    cores -> scheduler, per-core result valid (held until core_ack)
//   core_result  cores -> scheduler, per-core batch data, slice i for core i
//   core_start   scheduler -> cores, per-core 1-cycle start pulse
//   core_index   scheduler -> cores, batch index for the core being started
//   core_ack     scheduler -> cores, per-core 1-cycle result-consumed pulse
//   core_abort   scheduler -> cores, 1-cycle pulse: drop all work
//   fifo_enqueue scheduler -> FIFO, 1-cycle push of fifo_value
//   fifo_value   scheduler -> FIFO, batch data, pixel 0 in the MSBs
//   frame_done   scheduler -> frame timing, every batch of the frame retired
// Modport master is the scheduler side; slave is the core/FIFO/timing side.
interface batch_scheduler_if #(
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned BATCH_PIXELS = 8,
    parameter int unsigned PIXEL_WIDTH  = 12,
    parameter int unsigned INDEX_WIDTH  = 16
);
    logic                                          new_frame;
    logic                                          fifo_ready;
    logic [NUM_CORES-1:0]                          core_done;
    logic [NUM_CORES*BATCH_PIXELS*PIXEL_WIDTH-1:0] core_result;
    logic [NUM_CORES-1:0]                          core_start;
    logic [INDEX_WIDTH-1:0]                        core_index;
    logic [NUM_CORES-1:0]                          core_ack;
    logic                                          core_abort;
    logic                                          fifo_enqueue;
    logic [BATCH_PIXELS*PIXEL_WIDTH-1:0]           fifo_value;
    logic                                          frame_done;

    modport master (
        input  new_frame, fifo_ready, core_done, core_result,
        output core_start, core_index, core_ack, core_abort, fifo_enqueue, fifo_value,
               frame_done
    );

    modport slave (
        output new_frame, fifo_ready, core_done, core_result,
        input  core_start, core_index, core_ack, core_abort, fifo_enqueue, fifo_value,
               frame_done
    );
endinterface

// File: rtl/batch_scheduler.sv
// Batch scheduler for a group of pixel-processor cores feeding one pixel FIFO.
// Hands out consecutive batch indices to cores round-robin and retires finished batches
// into the FIFO strictly in issue order, so the display side sees pixels in raster order.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset; every output and all state cleared
//   bus    batch_scheduler_if.master: new_frame/fifo_ready/core_done/core_result in,
//          core_start/core_index/core_ack/core_abort/fifo_enqueue/fifo_value/frame_done out
// All outputs are registered.
module batch_scheduler #(
    parameter int unsigned NUM_CORES         = 4,
    parameter int unsigned BATCH_PIXELS      = 8,
    parameter int unsigned PIXEL_WIDTH       = 12,
    parameter int unsigned BATCHES_PER_FRAME = 38400,
    parameter int unsigned INDEX_WIDTH       = 16
) (
    input logic             clk,
    input logic             reset,
    batch_scheduler_if.master bus
);
    localparam int unsigned BatchWidth = BATCH_PIXELS * PIXEL_WIDTH;
    localparam int unsigned PtrWidth   = $clog2(NUM_CORES);
    localparam int unsigned OutWidth   = $clog2(NUM_CORES + 1);
    localparam int unsigned CountWidth = $clog2(BATCHES_PER_FRAME + 1);

    localparam logic [PtrWidth-1:0]   PtrOne   = PtrWidth'(1);
    localparam logic [OutWidth-1:0]   OutOne   = OutWidth'(1);
    localparam logic [OutWidth-1:0]   OutMax   = OutWidth'(NUM_CORES);
    localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);
    localparam logic [CountWidth-1:0] FrameEnd = CountWidth'(BATCHES_PER_FRAME);
    localparam logic [NUM_CORES-1:0]  CoreOne  = NUM_CORES'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                  state_q;
    logic [PtrWidth-1:0]     issue_ptr_q;
    logic [PtrWidth-1:0]     retire_ptr_q;
    logic [CountWidth-1:0]   next_index_q;
    logic [CountWidth-1:0]   retired_count_q;
    logic [OutWidth-1:0]     outstanding_q;

    logic                    do_issue;
    logic                    do_retire;
    logic [BatchWidth-1:0]   retire_data;

    always_comb begin
        // Decisions use registered counts only, so a retire never frees a slot for an
        // issue in the same cycle.
        do_issue = (state_q == StRun) && (outstanding_q < OutMax) &&
                   (next_index_q != FrameEnd);
        // outstanding_q != 0 keeps a stale core_done (left over from an aborted frame)
        // from being retired before anything has been issued to that core.
        // The ack gate gives the acked core one cycle to drop its done.
        do_retire = ((state_q == StRun) || (state_q == StDrain)) &&
                    (outstanding_q != '0) && bus.core_done[retire_ptr_q] &&
                    bus.fifo_ready && (bus.core_ack == '0);
        retire_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (retire_ptr_q == PtrWidth'(i)) begin
                retire_data = bus.core_result[i*BatchWidth +: BatchWidth];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            issue_ptr_q      <= '0;
            retire_ptr_q     <= '0;
            next_index_q     <= '0;
            retired_count_q  <= '0;
            outstanding_q    <= '0;
            bus.core_start   <= '0;
            bus.core_index   <= '0;
            bus.core_ack     <= '0;
            bus.core_abort   <= 1'b0;
            bus.fifo_enqueue <= 1'b0;
            bus.fifo_value   <= '0;
            bus.frame_done   <= 1'b0;
        end else if (bus.new_frame) begin
            // Restart overrides any issue or retire decided this cycle.
            state_q          <= StRun;
            issue_ptr_q      <= '0;
            retire_ptr_q     <= '0;
            next_index_q     <= '0;
            retired_count_q  <= '0;
            outstanding_q    <= '0;
            bus.core_start   <= '0;
            bus.core_index   <= '0;
            bus.core_ack     <= '0;
            bus.core_abort   <= 1'b1;
            bus.fifo_enqueue <= 1'b0;
            bus.frame_done   <= 1'b0;
        end else begin
            bus.core_abort   <= 1'b0;
            bus.core_start   <= do_issue ? (CoreOne << issue_ptr_q) : '0;
            bus.core_ack     <= do_retire ? (CoreOne << retire_ptr_q) : '0;
            bus.fifo_enqueue <= do_retire;

            if (do_issue) begin
                bus.core_index <= INDEX_WIDTH'(next_index_q);
                issue_ptr_q    <= issue_ptr_q + PtrOne;
                next_index_q   <= next_index_q + CountOne;
            end

            if (do_retire) begin
                bus.fifo_value  <= retire_data;
                retire_ptr_q    <= retire_ptr_q + PtrOne;
                retired_count_q <= retired_count_q + CountOne;
            end

            if (do_issue && !do_retire) begin
                outstanding_q <= outstanding_q + OutOne;
            end else if (!do_issue && do_retire) begin
                outstanding_q <= outstanding_q - OutOne;
            end

            unique case (state_q)
                StRun: begin
                    if (next_index_q == FrameEnd) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (outstanding_q == '0) begin
                        state_q        <= StDone;
                        bus.frame_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
